// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt sequencer.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SERVICE
  } state_t;

  localparam int unsigned NSRC_DEFAULT       = 4;
  localparam int unsigned VEC_BASE_DEFAULT   = 'hE0;
  localparam int unsigned VEC_STRIDE_DEFAULT = 4;
  localparam int unsigned CAUSE_W            = $clog2(NSRC_DEFAULT);

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
module prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: edge-latched sources, enable mask, take/return handshake
// with the controller at instruction boundaries, single-level (no nesting).
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned NSRC       = NSRC_DEFAULT,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NSRC-1:0]         irq,
  input  logic                    mask_we,
  input  logic [NSRC-1:0]         mask_wdata,
  input  logic                    boundary,
  input  logic                    busy,
  input  logic [NBITS-1:0]        pc_next,
  input  logic                    sret,
  output logic                    take,
  output logic [NBITS-1:0]        vector,
  output logic [$clog2(NSRC)-1:0] cause,
  output logic [NBITS-1:0]        sepc,
  output logic                    in_service,
  output logic [NSRC-1:0]         pending,
  output logic [NSRC-1:0]         mask
);

  localparam int unsigned CW = $clog2(NSRC);

  state_t          state, state_n;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] clr;
  logic [CW-1:0]   sel;
  logic [CW-1:0]   cause_q;
  logic            req_valid;
  logic            ret;

  assign rise = irq & ~irq_q;
  assign req  = pending & mask;

  prio_enc #(
    .N (NSRC),
    .W (CW)
  ) u_prio (
    .req   (req),
    .idx   (sel),
    .valid (req_valid)
  );

  // Cause tracks the live winner until taken, then holds for the handler.
  assign cause  = (state == SERVICE) ? cause_q : sel;
  assign vector = NBITS'(VEC_BASE + VEC_STRIDE * cause);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    ret     = 1'b0;
    clr     = '0;
    case (state)
      IDLE: begin
        if (req_valid) state_n = ARMED;
      end
      ARMED: begin
        take = boundary && !busy && req_valid;
        if (take) begin
          clr     = NSRC'(1) << sel;
          state_n = SERVICE;
        end else if (!req_valid) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        ret = boundary && sret && !busy;
        if (ret) state_n = req_valid ? ARMED : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      sepc       <= '0;
      in_service <= 1'b0;
      cause_q    <= '0;
    end else begin
      state <= state_n;
      irq_q <= irq;
      // A fresh edge on the source being taken survives the clear.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (take) begin
        sepc       <= pc_next;
        cause_q    <= sel;
        in_service <= 1'b1;
      end else if (ret) begin
        in_service <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed vector table plus hand-written corner sequences for irq_sequencer.
module tb_irq_sequencer;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq, mask_wdata, pending, mask;
  logic       mask_we, boundary, busy, sret, take, in_service;
  logic [7:0] pc_next, vector, sepc;
  logic [1:0] cause;

  logic [3:0] w_irq, w_mask_wdata, w_pending, w_mask;
  logic       w_mask_we, w_boundary, w_busy, w_sret, w_take, w_in_service;
  logic [7:0] w_pc_next, w_vector, w_sepc;
  logic [CAUSE_W-1:0] w_cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  irq_sequencer #(.NBITS(8), .NSRC(4), .VEC_BASE('hE0), .VEC_STRIDE(4)) dut (
    .clock(clk), .reset(rst_n), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .boundary(boundary), .busy(busy), .pc_next(pc_next), .sret(sret), .take(take),
    .vector(vector), .cause(cause), .sepc(sepc), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  irq_sequencer #(.NBITS(8), .NSRC(4), .VEC_BASE('hFC), .VEC_STRIDE(4)) u_wrap (
    .clock(clk), .reset(rst_n), .irq(w_irq), .mask_we(w_mask_we), .mask_wdata(w_mask_wdata),
    .boundary(w_boundary), .busy(w_busy), .pc_next(w_pc_next), .sret(w_sret), .take(w_take),
    .vector(w_vector), .cause(w_cause), .sepc(w_sepc), .in_service(w_in_service),
    .pending(w_pending), .mask(w_mask)
  );

  typedef struct {
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mwd;
    logic       bnd;
    logic       bsy;
    logic [7:0] pc;
    logic       sret;
    logic       e_take;
    logic [7:0] e_vec;
    logic [1:0] e_cause;
    logic [7:0] e_sepc;
    logic       e_ins;
    logic [3:0] e_pend;
    logic [3:0] e_mask;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic [3:0] i, logic we, logic [3:0] wd, logic b, logic bs,
                              logic [7:0] pc, logic s, logic t, logic [7:0] v, logic [1:0] c,
                              logic [7:0] ep, logic ins, logic [3:0] pd, logic [3:0] m);
    vec_t r;
    r.irq = i; r.mwe = we; r.mwd = wd; r.bnd = b; r.bsy = bs; r.pc = pc; r.sret = s;
    r.e_take = t; r.e_vec = v; r.e_cause = c; r.e_sepc = ep; r.e_ins = ins;
    r.e_pend = pd; r.e_mask = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    irq = v.irq; mask_we = v.mwe; mask_wdata = v.mwd; boundary = v.bnd;
    busy = v.bsy; pc_next = v.pc; sret = v.sret;
    #1;
    chk($sformatf("v%0d_take", idx), 32'(take), 32'(v.e_take));
    chk($sformatf("v%0d_vector", idx), 32'(vector), 32'(v.e_vec));
    chk($sformatf("v%0d_cause", idx), 32'(cause), 32'(v.e_cause));
    chk($sformatf("v%0d_sepc", idx), 32'(sepc), 32'(v.e_sepc));
    chk($sformatf("v%0d_in_service", idx), 32'(in_service), 32'(v.e_ins));
    chk($sformatf("v%0d_pending", idx), 32'(pending), 32'(v.e_pend));
    chk($sformatf("v%0d_mask", idx), 32'(mask), 32'(v.e_mask));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_take"}, 32'(take), 0);
    chk({tag, "_vector"}, 32'(vector), 32'hE0);
    chk({tag, "_cause"}, 32'(cause), 0);
    chk({tag, "_sepc"}, 32'(sepc), 0);
    chk({tag, "_in_service"}, 32'(in_service), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_mask"}, 32'(mask), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    irq = '0; mask_we = 1'b0; mask_wdata = '0; boundary = 1'b0; busy = 1'b0;
    pc_next = '0; sret = 1'b0;
    w_irq = '0; w_mask_we = 1'b0; w_mask_wdata = '0; w_boundary = 1'b0; w_busy = 1'b0;
    w_pc_next = '0; w_sret = 1'b0;

    // Single source 0, then priority and tail-chain of sources 1 and 3.
    tbl[0]  = mk(4'h0, 1, 4'h1, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h00, 0, 4'h0, 4'h0);
    tbl[1]  = mk(4'h1, 0, 4'h0, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h00, 0, 4'h0, 4'h1);
    tbl[2]  = mk(4'h1, 0, 4'h0, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h00, 0, 4'h1, 4'h1);
    tbl[3]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 0,  1, 8'hE0, 0, 8'h00, 0, 4'h1, 4'h1);
    tbl[4]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h24, 1, 4'h0, 4'h1);
    tbl[5]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 1,  0, 8'hE0, 0, 8'h24, 1, 4'h0, 4'h1);
    tbl[6]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h24, 0, 4'h0, 4'h1);
    tbl[7]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 1,  0, 8'hE0, 0, 8'h24, 0, 4'h0, 4'h1);
    tbl[8]  = mk(4'h0, 0, 4'h0, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h24, 0, 4'h0, 4'h1);
    tbl[9]  = mk(4'h0, 1, 4'hF, 1, 0, 8'h24, 0,  0, 8'hE0, 0, 8'h24, 0, 4'h0, 4'h1);
    tbl[10] = mk(4'hA, 0, 4'h0, 1, 0, 8'h30, 0,  0, 8'hE0, 0, 8'h24, 0, 4'h0, 4'hF);
    tbl[11] = mk(4'hA, 0, 4'h0, 0, 0, 8'h30, 0,  0, 8'hE4, 1, 8'h24, 0, 4'hA, 4'hF);
    tbl[12] = mk(4'h0, 0, 4'h0, 1, 0, 8'h30, 0,  1, 8'hE4, 1, 8'h24, 0, 4'hA, 4'hF);
    tbl[13] = mk(4'h0, 0, 4'h0, 1, 0, 8'h34, 0,  0, 8'hE4, 1, 8'h30, 1, 4'h8, 4'hF);
    tbl[14] = mk(4'h0, 0, 4'h0, 1, 0, 8'h34, 1,  0, 8'hE4, 1, 8'h30, 1, 4'h8, 4'hF);
    tbl[15] = mk(4'h0, 0, 4'h0, 1, 0, 8'h50, 0,  1, 8'hEC, 3, 8'h30, 0, 4'h8, 4'hF);
    tbl[16] = mk(4'h0, 0, 4'h0, 1, 0, 8'h50, 1,  0, 8'hEC, 3, 8'h50, 1, 4'h0, 4'hF);
    tbl[17] = mk(4'h0, 0, 4'h0, 1, 0, 8'h50, 0,  0, 8'hE0, 0, 8'h50, 0, 4'h0, 4'hF);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outputs("init_rst");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply(tbl[i], i);

    // Busy blocks take; clearing the mask disarms but keeps pending.
    @(negedge clk); irq = 4'h1; boundary = 1'b1; busy = 1'b1;
    @(negedge clk); irq = 4'h0; #1; chk("busy_idle_take", 32'(take), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("busy_block%0d", i), 32'(take), 0);
    end
    @(negedge clk); mask_we = 1'b1; mask_wdata = 4'h0; #1;
    chk("busy_maskwr_take", 32'(take), 0);
    @(negedge clk); mask_we = 1'b0; busy = 1'b0; #1;
    chk("masked_take", 32'(take), 0);
    chk("masked_mask", 32'(mask), 0);
    @(negedge clk); #1;
    chk("pend_retained", 32'(pending), 1);
    chk("idle_take", 32'(take), 0);
    @(negedge clk); mask_we = 1'b1; mask_wdata = 4'h1; #1;
    chk("reen_take0", 32'(take), 0);
    @(negedge clk); mask_we = 1'b0; #1;
    chk("reen_take1", 32'(take), 0);
    @(negedge clk); #1;
    chk("reen_take", 32'(take), 1);
    chk("reen_vector", 32'(vector), 32'hE0);
    @(negedge clk); sret = 1'b1;
    @(negedge clk); sret = 1'b0;

    // New edge on source 2 in its own take cycle stays pending.
    @(negedge clk); mask_we = 1'b1; mask_wdata = 4'h4; irq = 4'h4; boundary = 1'b0;
    @(negedge clk); mask_we = 1'b0; irq = 4'h0;
    @(negedge clk); irq = 4'h4; boundary = 1'b1; #1;
    chk("coll_take", 32'(take), 1);
    chk("coll_cause", 32'(cause), 2);
    chk("coll_vector", 32'(vector), 32'hE8);
    @(negedge clk); boundary = 1'b0; #1;
    chk("coll_pending", 32'(pending), 4);
    chk("coll_in_service", 32'(in_service), 1);
    chk("coll_no_nest", 32'(take), 0);
    @(negedge clk); sret = 1'b1; boundary = 1'b1;
    @(negedge clk); sret = 1'b0; pc_next = 8'h40; #1;
    chk("coll_take2", 32'(take), 1);
    chk("coll_cause2", 32'(cause), 2);
    @(negedge clk); boundary = 1'b0; #1;
    chk("coll_sepc", 32'(sepc), 32'h40);
    chk("coll_in_service2", 32'(in_service), 1);
    chk("coll_pending2", 32'(pending), 0);

    // Asynchronous reset while in service.
    #2 rst_n = 1'b0; irq = 4'h0; #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk); rst_n = 1'b1; boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_rst_take%0d", i), 32'(take), 0);
    end

    // Vector arithmetic wraps modulo 2^NBITS.
    @(negedge clk); w_mask_we = 1'b1; w_mask_wdata = 4'h2; w_irq = 4'h2;
    @(negedge clk); w_mask_we = 1'b0; #1;
    chk("wrap_cause", 32'(w_cause), 1);
    chk("wrap_vector", 32'(w_vector), 32'h00);
    @(negedge clk); w_boundary = 1'b1; #1;
    chk("wrap_take", 32'(w_take), 1);
    chk("wrap_vector_take", 32'(w_vector), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt sequencer for the 8-bit RISC-V core. It latches rising edges on NSRC external interrupt lines and holds an enable mask. At a legal instruction boundary it tells the controller to redirect fetch to a per-source vector, saving the return PC (sepc). On the return instruction it hands sepc back to the controller and re-arms. It sits beside the controller, between the external interrupt pins and the controller's PC-next mux.

## Interface
Parameters:
- NBITS, 8, PC / address width
- NSRC, 4, number of interrupt sources
- VEC_BASE, 'hE0, address of vector 0
- VEC_STRIDE, 4, byte distance between consecutive vectors

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- irq  in  NSRC  raw interrupt lines, synchronous to clock, rising-edge sensitive
- mask_we  in  1  write strobe for the enable mask
- mask_wdata  in  NSRC  new mask value (1 = enabled)
- boundary  in  1  controller retires an instruction this cycle
- busy  in  1  memory/cache busy; no take or return while high
- pc_next  in  NBITS  PC the controller would fetch next (PCPlus or branch target)
- sret  in  1  retiring instruction is the interrupt return
- take  out  1  redirect pc_ to vector this cycle; save pc_next
- vector  out  NBITS  VEC_BASE + VEC_STRIDE*cause, modulo 2^NBITS
- cause  out  $clog2(NSRC)  index of the selected/serviced source
- sepc  out  NBITS  saved return PC; controller loads it on sret
- in_service  out  1  a handler is running
- pending  out  NSRC  latched edge flags
- mask  out  NSRC  current enable mask

## Operation
- Edge detect: irq_q is a registered copy of irq. A pending[i] bit is set on the edge where irq[i]=1 and irq_q[i]=0. It is cleared only when that source is taken.
- Selection: fixed priority over pending & mask, lowest index wins. cause reflects the winner in IDLE/ARMED and is frozen in SERVICE.
- State machine (state type in package):
  - IDLE -> ARMED when |(pending & mask).
  - ARMED -> IDLE when |(pending & mask) becomes 0 (for example, the mask was cleared).
  - ARMED -> SERVICE on take.
  - SERVICE -> ARMED on return if |(pending & mask) (tail-chain), otherwise SERVICE -> IDLE.
- take = (state==ARMED) & boundary & !busy & |(pending & mask), combinational. The mask used is the registered value.
- On take: sepc <= pc_next; pending[cause] cleared; cause frozen; in_service <= 1.
- Return = (state==SERVICE) & boundary & sret & !busy. On return, in_service <= 0. The controller selects sepc as pc_ in that cycle.
- sret outside SERVICE is ignored. There is no nesting: interrupts are never taken in SERVICE.
- Mask write takes effect at the next edge. A write in the same cycle as take does not affect that take.
- A new edge on source i in the same cycle source i is taken: set wins, so pending[i] remains 1.
- Reset (low, any time, including mid-service) sets:
  - state=IDLE, in_service=0, sepc=0, pending=0, mask=0, irq_q=0, cause=0.
  - take therefore reads 0 and vector reads VEC_BASE.

## Timing
- Minimum latency from the irq rising edge to take: pending is set at edge 1, ARMED at edge 2, and take is asserted in the cycle after edge 2 if boundary & !busy.
- take and the return strobe are single-cycle; busy stretches them by blocking, never by holding.
- sepc, in_service, pending, and state update on the edge closing the take/return cycle.
- vector and cause are valid combinationally whenever take=1.
- All outputs except take are registered or derived from registered cause.

## Structure
- Package irq_pkg:
  - state enum {IDLE, ARMED, SERVICE};
  - VEC_BASE and VEC_STRIDE defaults;
  - localparam CAUSE_W = $clog2(NSRC).
- Sub-module prio_enc: NSRC-bit request vector to lowest-set index plus a valid flag; purely combinational, reusable.
- The vector adder is inline, truncated to NBITS.

## Test plan
- Reset: hold reset low mid-SERVICE with sepc='h40 -> every output reads zero, vector='hE0, take stays 0 after release.
- Single IRQ: mask='b0001, pulse irq[0], boundary every cycle, pc_next='h24 -> take in the 3rd cycle after the edge, vector='hE0, sepc='h24; then sret+boundary -> in_service=0, state IDLE.
- Priority/tail-chain: mask='b1111, edges on irq[3] and irq[1] in the same cycle -> first take has cause=1, vector='hE4; on return, ARMED immediately, next take has cause=3, vector='hEC.
- Busy and mask: ARMED with busy=1 for 5 cycles -> no take; clear the mask while ARMED -> IDLE, pending bit retained; re-enable -> take.
- Collision: new irq[2] edge in the take cycle for source 2 -> pending[2]=1 after take; second take after return.
- Wrap: VEC_BASE='hFC, cause=1 -> vector='h00.
